pipeline_hazard_controller: RTL

- Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB) and generates all stall, bubble, kill and freeze controls for the PC and pipeline registers.
- Keeps a shadow pipeline of destination-register info for EX/MEM/WB and derives ID-stage forwarding selects from it.
- Detects load-use hazards, branch/jump flushes and multi-cycle data-memory waits, with a memory watchdog and performance counters.
- Sits beside the control unit; the datapath consumes its outputs directly.

---
 rtl/pipeline_hazard_controller.sv | 97 +++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/freeze sequencing, ID forwarding selects, memory watchdog and counters
module pipeline_hazard_controller #(
  parameter int REG_AW = 3,
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_kill,
  output logic              idex_kill,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_error,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              mr;
  } shadow_t;
  localparam logic RUN = 1'b0;
  localparam logic MEM_WAIT = 1'b1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  shadow_t ex_q, mem_q, wb_q, id_e;
  logic freeze, load_use, br, lu, jmp, st, st_d, wait_max;
  logic [WW-1:0] wait_q, wait_d;
  function automatic logic hit(input shadow_t s, input logic [REG_AW-1:0] src, input logic use_src);
    return s.v & s.wr & (s.rd == src) & (|src) & use_src;
  endfunction
  always_comb begin
    freeze = mem_access & ~mem_ready;
    load_use = id_valid & ex_q.v & ex_q.mr & (|ex_q.rd) &
               ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
    br = ~freeze & ex_branch_taken;
    lu = ~freeze & ~ex_branch_taken & load_use;
    jmp = ~freeze & ~ex_branch_taken & ~load_use & id_jump & id_valid;
    pc_stall = freeze | lu;
    ifid_stall = freeze | lu;
    idex_bubble = lu;
    ifid_kill = br | jmp;
    idex_kill = br;
    pipe_freeze = freeze;
    fwd_a = (hit(ex_q, id_rs1, id_use_rs1) & ~ex_q.mr) ? 2'b01 :
            hit(mem_q, id_rs1, id_use_rs1) ? 2'b10 :
            hit(wb_q, id_rs1, id_use_rs1) ? 2'b11 : 2'b00;
    fwd_b = (hit(ex_q, id_rs2, id_use_rs2) & ~ex_q.mr) ? 2'b01 :
            hit(mem_q, id_rs2, id_use_rs2) ? 2'b10 :
            hit(wb_q, id_rs2, id_use_rs2) ? 2'b11 : 2'b00;
    id_e = {id_valid & id_reg_wr, id_rd, id_reg_wr, id_mem_rd};
    wait_max = wait_q == WW'(MEM_TIMEOUT);
    st_d = (st == RUN) ? (freeze ? MEM_WAIT : RUN) : (mem_ready ? RUN : MEM_WAIT);
    wait_d = (st == RUN) ? (freeze ? WW'(1) : '0) :
             mem_ready ? '0 :
             (freeze & ~wait_max) ? wait_q + 1'b1 : wait_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      st <= RUN;
      wait_q <= '0;
      mem_error <= 1'b0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!freeze) begin
        ex_q <= (br | lu) ? '0 : id_e;
        mem_q <= ex_q;
        wb_q <= mem_q;
      end
      st <= st_d;
      wait_q <= wait_d;
      mem_error <= mem_error | (wait_d == WW'(MEM_TIMEOUT));
      stall_cycles <= stall_cycles + CNT_W'((freeze | lu) & ~&stall_cycles);
      flush_count <= flush_count + CNT_W'((br | jmp) & ~&flush_count);
    end
  end
endmodule
